// File: rtl/multi_channel_instr_queue_pkg.sv
// Shared types for the multi-channel instruction queue: instruction-type encodings,
// channel indices and the compact queue entry.
package multi_channel_instr_queue_pkg;

  localparam logic [1:0] INSTR_TYPE_ARITHMETIC = 2'b00;
  localparam logic [1:0] INSTR_TYPE_RAM        = 2'b01;
  localparam logic [1:0] INSTR_TYPE_LD_ST      = 2'b10;
  localparam logic [1:0] INSTR_TYPE_ILLEGAL    = 2'b11;

  localparam int NUM_CH = 3;
  localparam logic [1:0] CH_MATH  = 2'd0;
  localparam logic [1:0] CH_DMA   = 2'd1;
  localparam logic [1:0] CH_CACHE = 2'd2;

  localparam int IQ_ADDR_W         = 18;
  localparam int IQ_PAYLOAD_W      = 10;
  localparam int IQ_LOG_COPY_WIDTH = 4;

  // Entry at the default widths; the channel FIFO redeclares it at its parameterised widths.
  typedef struct packed {
    logic [IQ_PAYLOAD_W-1:0]      payload;
    logic [IQ_LOG_COPY_WIDTH-1:0] copy_count;
    logic [IQ_ADDR_W-1:0]         cache_addr;
    logic [IQ_ADDR_W-1:0]         main_mem_addr;
    logic [IQ_ADDR_W-1:0]         d_cache_addr;
    logic [IQ_ADDR_W-1:0]         d_main_mem_addr;
  } iq_entry_t;

endpackage

// File: rtl/multi_channel_instr_queue_if.sv
// Write port and per-channel issue ports of the instruction queue.
// master = decoder/consumers side, slave = the queue.
interface multi_channel_instr_queue_if #(
  parameter int DEPTH          = 8,
  parameter int LOG_COPY_WIDTH = 4,
  parameter int ADDR_W         = 18,
  parameter int PAYLOAD_W      = 10
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic                      we;
  logic [1:0]                in_instr_type;
  logic [LOG_COPY_WIDTH-1:0] copy_count;
  logic [ADDR_W-1:0]         cache_addr;
  logic [ADDR_W-1:0]         main_mem_addr;
  logic [ADDR_W-1:0]         d_cache_addr;
  logic [ADDR_W-1:0]         d_main_mem_addr;
  logic [PAYLOAD_W-1:0]      in_payload;

  logic [2:0]                out_valid;
  logic [2:0]                out_ready;
  logic [2:0][PAYLOAD_W-1:0] out_payload;
  logic [2:0][ADDR_W-1:0]    out_cache_addr;
  logic [2:0][ADDR_W-1:0]    out_main_addr;
  logic [2:0]                out_last;
  logic [2:0]                full;
  logic [2:0][CNT_W-1:0]     count;
  logic                      empty;
  logic                      needs_reset;

  modport master (
    output we, in_instr_type, copy_count, cache_addr, main_mem_addr,
           d_cache_addr, d_main_mem_addr, in_payload, out_ready,
    input  out_valid, out_payload, out_cache_addr, out_main_addr, out_last,
           full, count, empty, needs_reset
  );

  modport slave (
    input  we, in_instr_type, copy_count, cache_addr, main_mem_addr,
           d_cache_addr, d_main_mem_addr, in_payload, out_ready,
    output out_valid, out_payload, out_cache_addr, out_main_addr, out_last,
           full, count, empty, needs_reset
  );

endinterface

// File: rtl/multi_channel_instr_queue_iq_channel_fifo.sv
// One channel of the instruction queue: compact entry FIFO plus beat expander.
// IQ_BYPASS_EN lets a write to an empty channel issue in the same cycle.
module iq_channel_fifo #(
  parameter int DEPTH          = 8,
  parameter int LOG_COPY_WIDTH = 4,
  parameter int ADDR_W         = 18,
  parameter int PAYLOAD_W      = 10,
  parameter int CNT_W          = $clog2(DEPTH + 1)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      push,
  input  logic [LOG_COPY_WIDTH-1:0] copy_count,
  input  logic [ADDR_W-1:0]         cache_addr,
  input  logic [ADDR_W-1:0]         main_mem_addr,
  input  logic [ADDR_W-1:0]         d_cache_addr,
  input  logic [ADDR_W-1:0]         d_main_mem_addr,
  input  logic [PAYLOAD_W-1:0]      in_payload,
  input  logic                      out_ready,
  output logic                      out_valid,
  output logic [PAYLOAD_W-1:0]      out_payload,
  output logic [ADDR_W-1:0]         out_cache_addr,
  output logic [ADDR_W-1:0]         out_main_addr,
  output logic                      out_last,
  output logic                      full,
  output logic [CNT_W-1:0]          count
);
  localparam int PTR_W = $clog2(DEPTH);

  typedef struct packed {
    logic [PAYLOAD_W-1:0]      payload;
    logic [LOG_COPY_WIDTH-1:0] copy_count;
    logic [ADDR_W-1:0]         cache_addr;
    logic [ADDR_W-1:0]         main_mem_addr;
    logic [ADDR_W-1:0]         d_cache_addr;
    logic [ADDR_W-1:0]         d_main_mem_addr;
  } entry_t;

  entry_t                    mem [DEPTH];
  entry_t                    wr_entry;
  entry_t                    cur;
  logic [PTR_W-1:0]          wr_ptr, rd_ptr;
  logic [CNT_W-1:0]          cnt;
  logic [LOG_COPY_WIDTH-1:0] beat, cur_beat;
  logic [ADDR_W-1:0]         off_cache, off_main, cur_off_cache, cur_off_main;
  logic                      stored_valid, valid_int, last_int;
  logic                      handshake, pop_stored, store;

  // Select the beat currently offered: normally the stored head, or the incoming
  // write when bypass is built in and the channel holds nothing.
  always_comb begin
    wr_entry      = '{payload: in_payload, copy_count: copy_count,
                      cache_addr: cache_addr, main_mem_addr: main_mem_addr,
                      d_cache_addr: d_cache_addr, d_main_mem_addr: d_main_mem_addr};
    stored_valid  = (cnt != '0);
    valid_int     = stored_valid;
    cur           = mem[rd_ptr];
    cur_beat      = beat;
    cur_off_cache = off_cache;
    cur_off_main  = off_main;
    store         = push;
`ifdef IQ_BYPASS_EN
    if (!stored_valid && push) begin
      valid_int     = 1'b1;
      cur           = wr_entry;
      cur_beat      = '0;
      cur_off_cache = '0;
      cur_off_main  = '0;
      if (out_ready && copy_count == '0) store = 1'b0;
    end
`endif
    last_int   = (cur_beat == cur.copy_count);
    handshake  = valid_int && out_ready;
    pop_stored = handshake && last_int && stored_valid;

    out_valid      = valid_int;
    out_payload    = '0;
    out_cache_addr = '0;
    out_main_addr  = '0;
    out_last       = 1'b0;
    if (valid_int) begin
      out_payload    = cur.payload;
      out_cache_addr = cur.cache_addr + cur_off_cache;
      out_main_addr  = cur.main_mem_addr + cur_off_main;
      out_last       = last_int;
    end
    full  = (cnt == CNT_W'(DEPTH));
    count = cnt;
  end

  // Entry storage holds no reset; only the pointers and count give it meaning.
  always_ff @(posedge clk) begin
    if (store) mem[wr_ptr] <= wr_entry;
  end

  // Pointers, occupancy and the per-beat offset accumulators.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      cnt       <= '0;
      beat      <= '0;
      off_cache <= '0;
      off_main  <= '0;
    end else begin
      if (store) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_stored) rd_ptr <= rd_ptr + PTR_W'(1);
      cnt <= cnt + CNT_W'(store) - CNT_W'(pop_stored);
      if (handshake) begin
        if (last_int) begin
          beat      <= '0;
          off_cache <= '0;
          off_main  <= '0;
        end else begin
          beat      <= cur_beat + LOG_COPY_WIDTH'(1);
          off_cache <= cur_off_cache + cur.d_cache_addr;
          off_main  <= cur_off_main + cur.d_main_mem_addr;
        end
      end
    end
  end

endmodule

// File: rtl/multi_channel_instr_queue.sv
// Multi-channel instruction queue: decodes the write to math/DMA/cache FIFOs, keeps the
// sticky error flag and the all-empty status. Optional same-cycle bypass: IQ_BYPASS_EN.
module multi_channel_instr_queue
  import multi_channel_instr_queue_pkg::*;
#(
  parameter int DEPTH          = 8,
  parameter int LOG_COPY_WIDTH = 4,
  parameter int ADDR_W         = 18,
  parameter int PAYLOAD_W      = 10
) (
  input logic                          clk,
  input logic                          reset,
  multi_channel_instr_queue_if.slave   bus
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [1:0]                sel;
  logic                      legal, refuse, needs_reset_q;
  logic [2:0]                push, valid, last, full;
  logic [2:0][PAYLOAD_W-1:0] payload;
  logic [2:0][ADDR_W-1:0]    caddr, maddr;
  logic [2:0][CNT_W-1:0]     cnt;

  // Route the write; full is the pre-pop view, so a same-cycle pop never frees a slot.
  always_comb begin
    sel    = CH_MATH;
    legal  = 1'b1;
    push   = '0;
    refuse = 1'b0;
    case (bus.in_instr_type)
      INSTR_TYPE_ARITHMETIC: sel = CH_MATH;
      INSTR_TYPE_RAM:        sel = CH_DMA;
      INSTR_TYPE_LD_ST:      sel = CH_CACHE;
      default:               legal = 1'b0;
    endcase
    if (bus.we) begin
      if (legal && !full[sel]) push[sel] = 1'b1;
      else                     refuse    = 1'b1;
    end
  end

  // Any dropped write leaves the queue inconsistent with the decoder until reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      needs_reset_q <= 1'b0;
    else if (refuse) needs_reset_q <= 1'b1;
  end

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    iq_channel_fifo #(
      .DEPTH(DEPTH), .LOG_COPY_WIDTH(LOG_COPY_WIDTH),
      .ADDR_W(ADDR_W), .PAYLOAD_W(PAYLOAD_W), .CNT_W(CNT_W)
    ) u_fifo (
      .clk             (clk),
      .reset           (reset),
      .push            (push[ch]),
      .copy_count      (bus.copy_count),
      .cache_addr      (bus.cache_addr),
      .main_mem_addr   (bus.main_mem_addr),
      .d_cache_addr    (bus.d_cache_addr),
      .d_main_mem_addr (bus.d_main_mem_addr),
      .in_payload      (bus.in_payload),
      .out_ready       (bus.out_ready[ch]),
      .out_valid       (valid[ch]),
      .out_payload     (payload[ch]),
      .out_cache_addr  (caddr[ch]),
      .out_main_addr   (maddr[ch]),
      .out_last        (last[ch]),
      .full            (full[ch]),
      .count           (cnt[ch])
    );
  end

  assign bus.out_valid      = valid;
  assign bus.out_payload    = payload;
  assign bus.out_cache_addr = caddr;
  assign bus.out_main_addr  = maddr;
  assign bus.out_last       = last;
  assign bus.full           = full;
  assign bus.count          = cnt;
  assign bus.empty          = (cnt == '0);
  assign bus.needs_reset    = needs_reset_q;

endmodule

// File: doc/multi_channel_instr_queue.md
Name: multi_channel_instr_queue

Overview:
- Parametrised successor to the single-output instruction queue: one FIFO per execution channel (math, DMA, cache), each with its own valid/ready issue port.
- Stores each write compactly as one entry (payload, copy_count, base addresses, strides).
- Expands each entry at issue into copy_count+1 beats with strided addresses.
- Sits between the control-unit decoder and the math, DMA and regfile/cache units.

Parameters:
- DEPTH, 8, entries per channel FIFO (power of two, ≥2)
- LOG_COPY_WIDTH, 4, width of copy_count; beats per entry = copy_count+1
- ADDR_W, 18, cache and main-memory address width
- PAYLOAD_W, 10, instruction payload width; narrower inputs zero-extended at MSB

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- we  in  1  write strobe
- in_instr_type  in  2  INSTR_TYPE_ARITHMETIC→ch0 (math), INSTR_TYPE_RAM→ch1 (DMA), INSTR_TYPE_LD_ST→ch2 (cache); 2'b11 illegal
- copy_count  in  LOG_COPY_WIDTH  beats-1
- cache_addr, main_mem_addr  in  ADDR_W each  base addresses
- d_cache_addr, d_main_mem_addr  in  ADDR_W each  per-beat strides
- in_payload  in  PAYLOAD_W  instruction bits
- out_valid  out  3  per-channel beat valid
- out_ready  in  3  per-channel consumer ready
- out_payload  out  3×PAYLOAD_W  head payload
- out_cache_addr, out_main_addr  out  3×ADDR_W each  beat addresses
- out_last  out  3  final beat of entry
- full  out  3  per-channel full
- count  out  3×$clog2(DEPTH+1)  per-channel occupancy
- empty  out  1  all channels empty
- needs_reset  out  1  sticky error flag

Behaviour:
- Reset (async assert, sync release): pointers, counts, beat index and offset accumulators = 0; out_valid = 0; full = 0; empty = 1; needs_reset = 0.
- All data outputs are forced to 0 whenever out_valid[ch] = 0, including during reset.
- Write accepted iff we, type ≠ 2'b11 and !full[ch]. full is sampled before any same-cycle pop, so a write to a full channel is refused even if that channel pops in the same cycle.
- Refused write (full channel or illegal type): entry dropped, needs_reset ← 1. needs_reset is cleared only by reset.
- Latency: write on edge N → out_valid on that channel from edge N onward (one-cycle write-to-issue).
- Beat k of the head entry: out_cache_addr = base + k·d_cache, out_main_addr = base + k·d_main, both mod 2^ADDR_W. Implemented with per-channel offset accumulators, no multiplier. out_last = (k == copy_count).
- Handshake = out_valid & out_ready. On a handshake: if out_last, pop the entry and clear k and the offsets; otherwise k++ and offsets += strides.
- While out_ready = 0, all outputs hold stable. out_valid never drops without a handshake.
- Channels are independent; order is preserved within a channel; there is no ordering between channels.
- count = stored entries, including any entry mid-expansion. full = (count == DEPTH). empty = all counts zero.
- Pointers wrap modulo DEPTH.

Optional Feature:
- Macro IQ_BYPASS_EN.
- Defined: a write to an empty channel drives out_valid combinationally in the same cycle from the input ports.
  - If out_ready is high and copy_count = 0, the entry is never stored.
  - If out_ready is high and copy_count > 0, the entry is stored with k = 1.
- Undefined: the one-cycle latency above applies.

Decomposition:
- Shared types package gains: INSTR_TYPE_* constants, CH_MATH/CH_DMA/CH_CACHE indices, and iq_entry_t struct {payload, copy_count, cache_addr, main_mem_addr, d_cache_addr, d_main_mem_addr}.
- Sub-module iq_channel_fifo: one FIFO plus expander, instantiated three times.
- Top level: type decode, error flag, empty reduction.

Test Plan:
- Release reset, then idle → out_valid = 3'b000, all data outputs === 0, empty = 1, count = 0.
- Arith write: copy_count = 15, payload = 10'h200, cache_addr = 18'h100, d_cache_addr = 4, out_ready = 3'b111 → 16 math beats with addresses 0x100…0x13C; out_last on beat 16 only; then empty = 1.
- Nine DMA writes with out_ready[1] = 0, DEPTH = 8 → full[1] = 1 after the 8th; the 9th is dropped and needs_reset = 1, still 1 after draining, 0 after reset.
- Cache write: cache_addr = 18'h3FFFE, d_cache_addr = 1, copy_count = 3 → beat addresses 3FFFE, 3FFFF, 00000, 00001.
- Interleaved writes to all channels with random out_ready toggling → per-channel order preserved, outputs stable while ready is low, 2'b11 type sets needs_reset.
- Reset asserted at beat 5 of 16 → out_valid = 0 asynchronously, empty = 1 after release.
  - With IQ_BYPASS_EN, copy_count = 0 to an empty channel with ready high → same-cycle valid, count stays 0.
